aes_ctr_stream: RTL and testbench
=================================

Name: aes_ctr_stream

Overview:
- CTR-mode front/back end for the iterative AES-256 datapath.
- Holds the 128-bit counter block and 256-bit key, and issues one counter block per data block to the AES core through a start/done handshake.
- XORs the returned keystream with the buffered plaintext or ciphertext, and presents the result on a valid/ready output.
- CTR is symmetric, so the core always runs in encrypt direction and the same block serves encryption and decryption.

Parameters:
CTR_WIDTH, 32, number of low-order counter bits incremented per block (1..128); upper 128-CTR_WIDTH bits never change.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  new IV/key offered
cfg_ready  out  1  config accepted when cfg_valid&cfg_ready
cfg_iv  in  128  initial counter block
cfg_key  in  256  master key
in_valid  in  1  input block offered
in_ready  out  1  input buffer empty
in_data  in  128  plaintext or ciphertext block
in_mask  in  16  byte enables, bit i = byte [8i+7:8i]; 0 forces output byte to 0
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  128  in_data ^ keystream, masked
core_start  out  1  one-cycle pulse: AES core begins a block
core_ctr  out  128  counter block to encrypt, stable from core_start until core_done
core_key  out  256  registered key to the core
core_done  in  1  one-cycle pulse: keystream valid
core_ks  in  128  keystream block, sampled on core_done
busy  out  1  high in S_RUN or S_OUT
ctr_wrap  out  1  one-cycle pulse when the low CTR_WIDTH bits wrap to 0

Behaviour:
- Reset (async, rst_n=0) clears all registers and outputs to 0: out_valid, out_data, core_start, core_ctr, core_key, ctr_wrap, busy, the input buffer, and the iv_loaded flag. The FSM returns to S_IDLE.
- A reset mid-block abandons the block. A core_done arriving after reset is ignored.
- Input buffer: 1 entry holding data, mask and inbuf_valid.
  - in_ready = ~inbuf_valid.
  - An accepted input sets inbuf_valid at the next edge.
  - The buffer accepts in any FSM state, so it can prefetch while the core runs.
- Config:
  - cfg_ready = (state==S_IDLE).
  - On accept, the counter register gets cfg_iv, core_key gets cfg_key, and iv_loaded is set.
  - If a start condition exists in the same cycle, config wins and the start is deferred one cycle so the block uses the new IV.
- FSM states: S_IDLE, S_RUN, S_OUT.
  - S_IDLE: if inbuf_valid && iv_loaded && !cfg accept, then at the next edge:
    - enter S_RUN;
    - core_start=1 for exactly that one cycle;
    - core_ctr <= ctr;
    - work_data/work_mask <= buffer, and inbuf_valid clears (unless a new input is accepted at the same edge);
    - ctr low CTR_WIDTH bits +1 mod 2^CTR_WIDTH.
  - S_RUN: wait for core_done.
    - On core_done: out_data <= (work_data ^ core_ks) with unmasked bytes zeroed, out_valid <= 1, state <= S_OUT.
    - core_done in the same cycle as core_start is illegal; the core latency is >=1 cycle after the start cycle.
  - S_OUT: hold out_valid/out_data stable until out_ready.
    - On handshake, out_valid <= 0.
    - If inbuf_valid (iv_loaded is necessarily 1), take the same start action as S_IDLE at that edge (back-to-back, no idle cycle).
    - Otherwise go to S_IDLE.
- core_done in S_IDLE or S_OUT is ignored.
- core_ctr and core_key change only at start or config edges.
- Counter wrap: when the low CTR_WIDTH bits are all 1 at increment, they become 0, the upper bits are unchanged, and ctr_wrap pulses one cycle aligned with core_start. Operation continues.
- Latency: with input accepted at edge E0 from S_IDLE, core_start is high in the cycle after E1. If the core asserts core_done L cycles after core_start, out_valid rises at the edge ending the core_done cycle. Total = L + 2 edges.
- Throughput: one block per (L + 2) cycles with out_ready tied high.
- busy = (state != S_IDLE).

Test Plan:
1. SP800-38A F.5.5 vector.
   - Stimulus: cfg_key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, cfg_iv=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, in_data=6bc1bee22e409f96e93d7e117393172a, mask=ffff, with the real AES-256 core.
   - Required: out_data=601ec313775789a5b7a7f504bbf3d228.
2. Second block streamed back-to-back, in_data=ae2d8a571e03ac9c9eb76fac45af8e51.
   - Required: core_ctr=f0f1f2f3f4f5f6f7f8f9fafbfcfdff00 and out_data=f443e3ca4d62b59aca84e990cacaf5c5.
   - Required: core_start the cycle after the first output handshake; in_ready high during S_RUN.
3. Decrypt: feed the ciphertexts from scenarios 1/2 after reloading the same IV.
   - Required: original plaintexts returned.
4. Backpressure: hold out_ready=0 for 20 cycles.
   - Required: out_data stable, one extra input buffered, in_ready=0 after that, no second core_start until the output drains.
5. Wrap, CTR_WIDTH=32, iv=...ffffffff, model core with ks=0.
   - Required: ctr_wrap pulse with core_start; next core_ctr low word=00000000, upper 96 bits unchanged.
6. Mask and reset.
   - Required: in_mask=00ff gives output bytes 15..8 = 00.
   - Required: rst_n pulse during S_RUN clears out_valid/busy, and a late core_done produces no output.

Source files
------------

// File: rtl/aes_ctr_stream_if.sv
// Port bundle for aes_ctr_stream. It groups the config, data-in, data-out and AES-core handshakes.
// The slave modport is the CTR block's view; master is the environment's view.
interface aes_ctr_stream_if;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [127:0] cfg_iv;
  logic [255:0] cfg_key;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [15:0]  in_mask;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         core_start;
  logic [127:0] core_ctr;
  logic [255:0] core_key;
  logic         core_done;
  logic [127:0] core_ks;
  logic         busy;
  logic         ctr_wrap;

  modport slave (
    input  cfg_valid, cfg_iv, cfg_key, in_valid, in_data, in_mask, out_ready,
           core_done, core_ks,
    output cfg_ready, in_ready, out_valid, out_data, core_start, core_ctr,
           core_key, busy, ctr_wrap
  );

  modport master (
    output cfg_valid, cfg_iv, cfg_key, in_valid, in_data, in_mask, out_ready,
           core_done, core_ks,
    input  cfg_ready, in_ready, out_valid, out_data, core_start, core_ctr,
           core_key, busy, ctr_wrap
  );
endinterface

// File: rtl/aes_ctr_stream.sv
// CTR-mode wrapper around an iterative AES-256 core: it issues counter blocks and XORs the
// returned keystream with buffered data. The core always runs in the encrypt direction.

module aes_ctr_xor_lane (
  input  logic [7:0] data_i,
  input  logic [7:0] ks_i,
  input  logic       en_i,
  output logic [7:0] res_o
);
  assign res_o = en_i ? (data_i ^ ks_i) : 8'h00;
endmodule

module aes_ctr_stream #(
  parameter int CTR_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  aes_ctr_stream_if.slave bus
);
  localparam int NUM_LANES = 16;
  localparam logic [127:0] LOW_MASK = (CTR_WIDTH >= 128) ? {128{1'b1}}
                                    : ((128'd1 << CTR_WIDTH) - 128'd1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_e;

  state_e       state_q, state_d;
  logic [127:0] ctr_q;
  logic [255:0] key_q;
  logic         iv_loaded_q;
  logic         inbuf_valid_q;
  logic [127:0] inbuf_data_q;
  logic [15:0]  inbuf_mask_q;
  logic [127:0] work_data_q;
  logic [15:0]  work_mask_q;
  logic [127:0] core_ctr_q;
  logic         core_start_q;
  logic         ctr_wrap_q;
  logic         out_valid_q;
  logic [127:0] out_data_q;

  logic         cfg_acc, in_acc, out_hs, start_go, done_acc;
  logic [127:0] ctr_inc;
  logic         ctr_at_max;
  logic [NUM_LANES-1:0][7:0] lane_res;

  assign cfg_acc  = bus.cfg_valid && (state_q == S_IDLE);
  assign in_acc   = bus.in_valid && !inbuf_valid_q;
  assign out_hs   = out_valid_q && bus.out_ready;
  assign done_acc = bus.core_done && (state_q == S_RUN);

  // Only the low CTR_WIDTH bits count; the upper bits of the IV are carried through unchanged.
  assign ctr_inc    = (ctr_q & ~LOW_MASK) | ((ctr_q + 128'd1) & LOW_MASK);
  assign ctr_at_max = &(ctr_q | ~LOW_MASK);

  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A config accept takes priority, so the next block sees the new IV.
        if (inbuf_valid_q && iv_loaded_q && !cfg_acc) begin
          start_go = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.core_done) state_d = S_OUT;
      end
      S_OUT: begin
        if (out_hs) begin
          if (inbuf_valid_q) begin
            start_go = 1'b1;
            state_d  = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q       <= '0;
      key_q       <= '0;
      iv_loaded_q <= 1'b0;
    end else if (cfg_acc) begin
      ctr_q       <= bus.cfg_iv;
      key_q       <= bus.cfg_key;
      iv_loaded_q <= 1'b1;
    end else if (start_go) begin
      ctr_q <= ctr_inc;
    end
  end

  // Single-entry input buffer; it fills in any state so the next block can prefetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inbuf_valid_q <= 1'b0;
      inbuf_data_q  <= '0;
      inbuf_mask_q  <= '0;
    end else if (in_acc) begin
      inbuf_valid_q <= 1'b1;
      inbuf_data_q  <= bus.in_data;
      inbuf_mask_q  <= bus.in_mask;
    end else if (start_go) begin
      inbuf_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_data_q  <= '0;
      work_mask_q  <= '0;
      core_ctr_q   <= '0;
      core_start_q <= 1'b0;
      ctr_wrap_q   <= 1'b0;
    end else begin
      core_start_q <= start_go;
      ctr_wrap_q   <= start_go && ctr_at_max;
      if (start_go) begin
        work_data_q <= inbuf_data_q;
        work_mask_q <= inbuf_mask_q;
        core_ctr_q  <= ctr_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    aes_ctr_xor_lane u_lane (
      .data_i (work_data_q[8*g +: 8]),
      .ks_i   (bus.core_ks[8*g +: 8]),
      .en_i   (work_mask_q[g]),
      .res_o  (lane_res[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (done_acc) begin
      out_valid_q <= 1'b1;
      out_data_q  <= lane_res;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.cfg_ready  = (state_q == S_IDLE);
  assign bus.in_ready   = !inbuf_valid_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.core_start = core_start_q;
  assign bus.core_ctr   = core_ctr_q;
  assign bus.core_key   = key_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.ctr_wrap   = ctr_wrap_q;
endmodule

// File: tb/tb_aes_ctr_stream.sv
// Bench for aes_ctr_stream. A behavioural AES core returns the known SP800-38A keystreams and a
// synthetic keystream for any other counter; a queue scoreboard checks every output handshake.
`timescale 1ns/1ps
module tb_aes_ctr_stream;
  localparam logic [255:0] KEY  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] IV1  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV2  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] IV3  = 128'h1234567890abcdef0011223344556677;
  localparam logic [127:0] IVW  = 128'hdeadbeefcafef00d13579bdfffffffff;
  localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1   = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] C2   = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  localparam logic [127:0] KS1  = 128'h0bdf7df1591716335e9a8b15c860c502;
  localparam logic [127:0] KS2  = 128'h5a6e699d536119065433863c8f657b94;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_ctr_stream_if bus();
  aes_ctr_stream #(.CTR_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int core_lat = 3;
  bit ks_zero = 1'b0;
  logic [127:0] tb_ctr = '0;
  logic [255:0] tb_key = '0;
  logic [127:0] exp_q[$];
  int acc_cyc[$], start_cyc[$], hs_cyc[$], ov_rise_cyc[$];
  logic [127:0] start_ctr[$];
  logic start_wrap[$];
  int wrap_cnt = 0;
  logic ov_prev = 1'b0;
  logic [127:0] last_out = '0;

  function automatic logic [127:0] ks_fn(input logic [127:0] c, input logic [255:0] k, input bit z);
    if (z) return '0;
    if (k == KEY && c == IV1) return KS1;
    if (k == KEY && c == IV2) return KS2;
    return c ^ k[255:128] ^ k[127:0] ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  function automatic logic [127:0] mask_fn(input logic [127:0] d, input logic [15:0] m);
    logic [127:0] r;
    r = d;
    for (int i = 0; i < 16; i++) if (!m[i]) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [127:0] calc_exp(input logic [127:0] d, input logic [15:0] m);
    return mask_fn(d ^ ks_fn(tb_ctr, tb_key, ks_zero), m);
  endfunction

  // Behavioural core: keystream arrives core_lat cycles after the start cycle.
  int m_cnt = 0;
  logic [127:0] m_ctr = '0;
  logic [255:0] m_key = '0;
  logic m_done = 1'b0;
  logic [127:0] m_ks = '0;
  assign bus.core_done = m_done;
  assign bus.core_ks   = m_ks;

  always @(posedge clk) begin
    cyc++;
    #1;
    m_done = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_ks   = ks_fn(m_ctr, m_key, ks_zero);
      end
    end
    if (bus.core_start) begin
      m_ctr = bus.core_ctr;
      m_key = bus.core_key;
      m_cnt = core_lat;
    end
  end

  // Event log and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
      if (bus.ctr_wrap) wrap_cnt++;
      if (bus.core_start) begin
        start_cyc.push_back(cyc);
        start_ctr.push_back(bus.core_ctr);
        start_wrap.push_back(bus.ctr_wrap);
      end
      if (bus.out_valid && !ov_prev) ov_rise_cyc.push_back(cyc);
      if (bus.out_valid && bus.out_ready) begin
        logic [127:0] e;
        hs_cyc.push_back(cyc);
        last_out = bus.out_data;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL scoreboard_extra: out_data=%h with nothing expected", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            n_errors++;
            $display("FAIL scoreboard_data: got %h, expected %h", bus.out_data, e);
          end
        end
      end
    end
    ov_prev = bus.out_valid;
  end

  task automatic clear_logs();
    acc_cyc.delete(); start_cyc.delete(); hs_cyc.delete(); ov_rise_cyc.delete();
    start_ctr.delete(); start_wrap.delete(); wrap_cnt = 0;
  endtask

  task automatic do_cfg(input logic [127:0] iv, input logic [255:0] key);
    int t = 0;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1; bus.cfg_iv = iv; bus.cfg_key = key;
    @(negedge clk);
    while (!bus.cfg_ready && t < 500) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 500) begin n_errors++; $display("FAIL cfg_timeout: cfg_ready=%b, expected 1", bus.cfg_ready); end
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    tb_ctr = iv; tb_key = key;
  endtask

  task automatic send(input logic [127:0] d, input logic [15:0] m, input logic [127:0] e);
    int t = 0;
    exp_q.push_back(e);
    tb_ctr = {tb_ctr[127:32], tb_ctr[31:0] + 32'd1};
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_mask = m;
    @(negedge clk);
    while (!bus.in_ready && t < 500) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 500) begin n_errors++; $display("FAIL send_timeout: in_ready=%b, expected 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && !bus.busy && bus.in_ready && !bus.out_valid) && t < 1000) begin
      @(negedge clk); t++;
    end
    n_checks++;
    if (t >= 1000) begin
      n_errors++;
      $display("FAIL idle_timeout: pending=%0d busy=%b, expected 0 and 0", exp_q.size(), bus.busy);
    end
  endtask

  task automatic wait_starts(input int n);
    int t = 0;
    while (start_cyc.size() < n && t < 500) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 500) begin n_errors++; $display("FAIL start_timeout: starts=%0d, expected %0d", start_cyc.size(), n); end
  endtask

  task automatic test_reset();
    bus.cfg_valid = 0; bus.cfg_iv = '0; bus.cfg_key = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_mask = '0; bus.out_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 9;
    if (bus.out_valid !== 1'b0)  begin n_errors++; $display("FAIL rst_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.out_data !== '0)     begin n_errors++; $display("FAIL rst_out_data: got %h, expected 0", bus.out_data); end
    if (bus.core_start !== 1'b0) begin n_errors++; $display("FAIL rst_core_start: got %b, expected 0", bus.core_start); end
    if (bus.core_ctr !== '0)     begin n_errors++; $display("FAIL rst_core_ctr: got %h, expected 0", bus.core_ctr); end
    if (bus.core_key !== '0)     begin n_errors++; $display("FAIL rst_core_key: got %h, expected 0", bus.core_key); end
    if (bus.ctr_wrap !== 1'b0)   begin n_errors++; $display("FAIL rst_ctr_wrap: got %b, expected 0", bus.ctr_wrap); end
    if (bus.busy !== 1'b0)       begin n_errors++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    if (bus.in_ready !== 1'b1)   begin n_errors++; $display("FAIL rst_in_ready: got %b, expected 1", bus.in_ready); end
    if (bus.cfg_ready !== 1'b1)  begin n_errors++; $display("FAIL rst_cfg_ready: got %b, expected 1", bus.cfg_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_vector();
    clear_logs();
    core_lat = 3; ks_zero = 1'b0;
    bus.out_ready = 1'b1;
    do_cfg(IV1, KEY);
    send(P1, 16'hffff, C1);
    wait_starts(1);
    n_checks += 2;
    if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL run_in_ready: got %b, expected 1", bus.in_ready); end
    if (bus.busy !== 1'b1)     begin n_errors++; $display("FAIL run_busy: got %b, expected 1", bus.busy); end
    send(P2, 16'hffff, C2);
    wait_idle();
    n_checks += 5;
    if (start_ctr[0] !== IV1) begin n_errors++; $display("FAIL vec_ctr0: got %h, expected %h", start_ctr[0], IV1); end
    if (start_ctr[1] !== IV2) begin n_errors++; $display("FAIL vec_ctr1: got %h, expected %h", start_ctr[1], IV2); end
    if (start_cyc[0] != acc_cyc[0] + 2)
      begin n_errors++; $display("FAIL start_latency: start cycle %0d, expected %0d", start_cyc[0], acc_cyc[0] + 2); end
    if (ov_rise_cyc[0] != start_cyc[0] + core_lat + 1)
      begin n_errors++; $display("FAIL out_latency: valid cycle %0d, expected %0d", ov_rise_cyc[0], start_cyc[0] + core_lat + 1); end
    if (start_cyc[1] != hs_cyc[0] + 1)
      begin n_errors++; $display("FAIL back_to_back: start cycle %0d, expected %0d", start_cyc[1], hs_cyc[0] + 1); end
  endtask

  task automatic test_decrypt();
    clear_logs();
    do_cfg(IV1, KEY);
    send(C1, 16'hffff, P1);
    send(C2, 16'hffff, P2);
    wait_idle();
    n_checks++;
    if (start_ctr[0] !== IV1) begin n_errors++; $display("FAIL dec_ctr0: got %h, expected %h", start_ctr[0], IV1); end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    bit stable = 1'b1, full = 1'b1, valid_held = 1'b1;
    int t = 0;
    clear_logs();
    bus.out_ready = 1'b0;
    do_cfg(IV3, KEY2);
    send(128'h00112233445566778899aabbccddeeff, 16'hffff, calc_exp(128'h00112233445566778899aabbccddeeff, 16'hffff));
    while (!bus.out_valid && t < 200) begin @(negedge clk); t++; end
    held = bus.out_data;
    send(128'h0f0e0d0c0b0a09080706050403020100, 16'hffff, calc_exp(128'h0f0e0d0c0b0a09080706050403020100, 16'hffff));
    repeat (20) begin
      @(negedge clk);
      if (bus.out_data !== held) stable = 1'b0;
      if (bus.in_ready !== 1'b0) full = 1'b0;
      if (bus.out_valid !== 1'b1) valid_held = 1'b0;
    end
    n_checks += 4;
    if (!stable)     begin n_errors++; $display("FAIL bp_stable: out_data now %h, expected %h", bus.out_data, held); end
    if (!full)       begin n_errors++; $display("FAIL bp_in_ready: in_ready went high, expected 0"); end
    if (!valid_held) begin n_errors++; $display("FAIL bp_valid: out_valid dropped, expected 1"); end
    if (start_cyc.size() != 1) begin n_errors++; $display("FAIL bp_starts: got %0d, expected 1", start_cyc.size()); end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle();
    n_checks += 2;
    if (start_cyc.size() != 2) begin n_errors++; $display("FAIL bp_drain_starts: got %0d, expected 2", start_cyc.size()); end
    if (start_cyc[1] != hs_cyc[0] + 1)
      begin n_errors++; $display("FAIL bp_restart: start cycle %0d, expected %0d", start_cyc[1], hs_cyc[0] + 1); end
  endtask

  task automatic test_wrap();
    clear_logs();
    ks_zero = 1'b1;
    do_cfg(IVW, KEY2);
    send(128'hcafebabe000000011111111122222222, 16'hffff, calc_exp(128'hcafebabe000000011111111122222222, 16'hffff));
    send(128'h33333333444444445555555566666666, 16'hffff, calc_exp(128'h33333333444444445555555566666666, 16'hffff));
    wait_idle();
    n_checks += 6;
    if (start_ctr[0] !== IVW)   begin n_errors++; $display("FAIL wrap_ctr0: got %h, expected %h", start_ctr[0], IVW); end
    if (start_wrap[0] !== 1'b1) begin n_errors++; $display("FAIL wrap_pulse: got %b, expected 1", start_wrap[0]); end
    if (start_wrap[1] !== 1'b0) begin n_errors++; $display("FAIL wrap_second: got %b, expected 0", start_wrap[1]); end
    if (start_ctr[1][31:0] !== 32'h0)
      begin n_errors++; $display("FAIL wrap_low: got %h, expected 00000000", start_ctr[1][31:0]); end
    if (start_ctr[1][127:32] !== IVW[127:32])
      begin n_errors++; $display("FAIL wrap_upper: got %h, expected %h", start_ctr[1][127:32], IVW[127:32]); end
    if (wrap_cnt != 1) begin n_errors++; $display("FAIL wrap_count: got %0d, expected 1", wrap_cnt); end
    ks_zero = 1'b0;
  endtask

  task automatic test_mask_reset();
    bit ov_seen = 1'b0, busy_seen = 1'b0;
    clear_logs();
    do_cfg(IV3, KEY2);
    send(128'hffeeddccbbaa99887766554433221100, 16'h00ff, calc_exp(128'hffeeddccbbaa99887766554433221100, 16'h00ff));
    wait_idle();
    n_checks++;
    if (last_out[127:64] !== 64'h0) begin n_errors++; $display("FAIL mask_upper: got %h, expected 0", last_out[127:64]); end
    clear_logs();
    core_lat = 8;
    send(128'h0123456789abcdeffedcba9876543210, 16'hffff, calc_exp(128'h0123456789abcdeffedcba9876543210, 16'hffff));
    wait_starts(1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    n_checks += 3;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL rr_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.busy !== 1'b0)      begin n_errors++; $display("FAIL rr_busy: got %b, expected 0", bus.busy); end
    if (bus.core_ctr !== '0)    begin n_errors++; $display("FAIL rr_core_ctr: got %h, expected 0", bus.core_ctr); end
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen = 1'b1;
      if (bus.busy) busy_seen = 1'b1;
    end
    n_checks += 2;
    if (ov_seen)   begin n_errors++; $display("FAIL late_done_out: out_valid rose, expected 0"); end
    if (busy_seen) begin n_errors++; $display("FAIL late_done_busy: busy rose, expected 0"); end
    core_lat = 3;
  endtask

  initial begin
    test_reset();
    test_vector();
    wait_idle();
    test_decrypt();
    test_backpressure();
    test_wrap();
    test_mask_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
